// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: opcodes, FSM states and datapath select codes for the multi-cycle RV32I controller
package riscv_mc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_LUI, S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        return (op == OP_STORE)  ? IMM_S :
               (op == OP_BRANCH) ? IMM_B :
               (op == OP_JAL)    ? IMM_J :
               (op == OP_LUI)    ? IMM_U : IMM_I;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps func3/func7[5] to ALUControl and flags func3 values the datapath cannot execute
module mc_alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       is_rtype,
    output logic [2:0] alu_control,
    output logic       bad_funct
);

    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (func3)
            3'b000:  alu_control = (is_rtype && func7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b100:  alu_control = ALU_XOR;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: bad_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multi-cycle RV32I datapath.
// Define MC_ILLEGAL_TRAP_EN to add the illegal output and a HALT state for bad instructions.
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       negative,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    state_t     state_q, state_d;
    logic [2:0] alu_dec;
    logic       bad_funct;

    mc_alu_decoder u_alu_dec (
        .func3      (func3),
        .func7_5    (func7[5]),
        .is_rtype   (opcode == OP_RTYPE),
        .alu_control(alu_dec),
        .bad_funct  (bad_funct)
    );

`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t S_UNKNOWN = S_HALT;
    logic bad_f3;
    assign bad_f3 = (bad_funct && (opcode == OP_RTYPE || opcode == OP_ITYPE)) ||
                    (opcode == OP_BRANCH && func3 != 3'b000 && func3 != 3'b001 &&
                     func3 != 3'b100 && func3 != 3'b101);
`else
    localparam state_t S_UNKNOWN = S_FETCH;
    // Without the trap an unsupported func3 simply executes as add.
    logic unused_bad_funct;
    assign unused_bad_funct = bad_funct;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = imm_src_of(opcode);
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_UNKNOWN;
                endcase
`ifdef MC_ILLEGAL_TRAP_EN
                if (bad_f3) state_d = S_HALT;
`endif
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                ALUControl = alu_dec;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_dec;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUControl = ALU_SUB;
                PCWrite    = (func3 == 3'b000) ? zero :
                             (func3 == 3'b001) ? ~zero :
                             (func3 == 3'b100) ? negative :
                             (func3 == 3'b101) ? ~negative : 1'b0;
                state_d    = S_FETCH;
            end
            S_JAL, S_JALRPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALRPC;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMMEXT;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: illegal = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase
        // Nothing may write while reset is held, whatever state we were in.
        if (rst) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = RES_ALUOUT;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_B;
            ImmSrc     = IMM_I;
            ALUControl = ALU_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal    = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench; per-cycle expected control words are queued per instruction
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic [2:0] func3 = 3'b0;
    logic [6:0] func7 = 7'b0;
    logic       zero = 1'b0;
    logic       negative = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .zero(zero), .negative(negative), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
`ifdef MC_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];
    logic [16:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    function automatic logic [16:0] cw(input logic pc, adr, mw, ir, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] imm, alu);
        return {pc, adr, mw, ir, rw, rs, sa, sb, imm, alu};
    endfunction

    logic [16:0] fetch_w;
    logic [16:0] aluwb_w;
    initial begin
        fetch_w = cw(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000);
        aluwb_w = cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            #1 check(tag, {15'b0, act}, {15'b0, exp_q.pop_front()});
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic n, input logic [2:0] alu,
                         input logic take, input string tag);
        logic [2:0] imm;
        opcode = op; func3 = f3; func7 = f7; zero = z; negative = n;
        imm = (op == 7'b0100011) ? 3'b001 : (op == 7'b1100011) ? 3'b010 :
              (op == 7'b1101111) ? 3'b011 : (op == 7'b0110111) ? 3'b100 : 3'b000;
        exp_q.push_back(fetch_w);
        exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000));
        case (op)
            7'b0000011: begin
                exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
                exp_q.push_back(cw(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
                exp_q.push_back(cw(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000));
            end
            7'b0100011: begin
                exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
                exp_q.push_back(cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
            end
            7'b0110011: begin
                exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu));
                exp_q.push_back(aluwb_w);
            end
            7'b0010011: begin
                exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu));
                exp_q.push_back(aluwb_w);
            end
            7'b1100011: exp_q.push_back(cw(take, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001));
            7'b1101111: begin
                exp_q.push_back(cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000));
                exp_q.push_back(aluwb_w);
            end
            7'b1100111: begin
                exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
                exp_q.push_back(cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000));
                exp_q.push_back(aluwb_w);
            end
            7'b0110111: exp_q.push_back(cw(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b100, 3'b000));
            default: ;
        endcase
        drain(tag);
    endtask

`ifdef MC_ILLEGAL_TRAP_EN
    task automatic trap(input logic [6:0] op, input logic [2:0] f3, input string tag);
        opcode = op; func3 = f3; func7 = 7'b0;
        exp_q.push_back(fetch_w);
        exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000));
        drain(tag);
        for (int i = 0; i < 10; i++) begin
            #1 check({tag, "_halt"}, {15'b0, act}, 32'd0);
            check({tag, "_illegal"}, {31'b0, illegal}, 32'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        #1 check({tag, "_clr"}, {31'b0, illegal}, 32'd0);
        rst = 1'b0;
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("rst_enables", {28'b0, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
        rst = 1'b0;
        #1 check("rel_ir_pc", {30'b0, IRWrite, PCWrite}, 32'd3);
        issue(7'b0110011, 3'b000, 7'b0100000, 0, 0, 3'b001, 0, "sub");
        issue(7'b0110011, 3'b000, 7'b0000000, 0, 0, 3'b000, 0, "add");
        issue(7'b0110011, 3'b100, 7'b0000000, 0, 0, 3'b101, 0, "xor");
        issue(7'b0110011, 3'b110, 7'b0000000, 0, 0, 3'b011, 0, "or");
        issue(7'b0110011, 3'b111, 7'b0000000, 0, 0, 3'b010, 0, "and");
        issue(7'b0110011, 3'b010, 7'b0000000, 0, 0, 3'b100, 0, "slt");
        issue(7'b0010011, 3'b000, 7'b0100000, 0, 0, 3'b000, 0, "addi");
        issue(7'b0010011, 3'b111, 7'b0000000, 0, 0, 3'b010, 0, "andi");
        issue(7'b0000011, 3'b010, 7'b0000000, 0, 0, 3'b000, 0, "lw");
        issue(7'b0100011, 3'b010, 7'b0000000, 0, 0, 3'b000, 0, "sw");
        issue(7'b1100011, 3'b000, 7'b0000000, 1, 0, 3'b000, 1, "beq_t");
        issue(7'b1100011, 3'b000, 7'b0000000, 0, 0, 3'b000, 0, "beq_nt");
        issue(7'b1100011, 3'b001, 7'b0000000, 0, 0, 3'b000, 1, "bne_t");
        issue(7'b1100011, 3'b100, 7'b0000000, 0, 1, 3'b000, 1, "blt_t");
        issue(7'b1100011, 3'b101, 7'b0000000, 0, 1, 3'b000, 0, "bge_nt");
        issue(7'b1101111, 3'b000, 7'b0000000, 0, 0, 3'b000, 0, "jal");
        issue(7'b1100111, 3'b000, 7'b0000000, 0, 0, 3'b000, 0, "jalr");
        issue(7'b0110111, 3'b000, 7'b0000000, 0, 0, 3'b000, 0, "lui");
`ifdef MC_ILLEGAL_TRAP_EN
        trap(7'b1111111, 3'b000, "illop");
        trap(7'b0110011, 3'b001, "badf3");
`else
        issue(7'b1111111, 3'b000, 7'b0000000, 0, 0, 3'b000, 0, "nop");
        issue(7'b0110011, 3'b001, 7'b0000000, 0, 0, 3'b000, 0, "badf3_add");
        issue(7'b1100011, 3'b010, 7'b0000000, 1, 1, 3'b000, 0, "badbr");
`endif
        // Reset landing in MEMWB, where RegWrite would otherwise be high.
        opcode = 7'b0000011; func3 = 3'b010;
        repeat (4) @(negedge clk);
        #1 check("pre_mid_rst", {31'b0, RegWrite}, 32'd1);
        rst = 1'b1;
        #1 check("mid_rst_en", {28'b0, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
        @(negedge clk);
        #1 check("mid_rst_en2", {28'b0, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
        rst = 1'b0;
        issue(7'b0110111, 3'b000, 7'b0000000, 0, 0, 3'b000, 0, "lui_after_rst");
        exp_q.push_back(fetch_w);
        drain("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I datapath. Sits directly upstream of that datapath and drives all of its select and write-enable lines.
- Consumes opcode/func3/func7 from the instruction register, and zero/negative from the ALU.
- Moore outputs per state. The only exception is PCWrite in BRANCH, which also depends on the flags.

Parameters:
- none (encodings are fixed in the package)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- func3  in  3  IR[14:12]
- func7  in  7  IR[31:25]
- zero  in  1  ALU result == 0
- negative  in  1  ALU result sign
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write
- IRWrite  out  1  IR and OldPC enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 B, 01 ImmExt, 10 const 4
- ImmSrc  out  3  I=000, S=001, B=010, J=011, U=100
- ALUControl  out  3  add 000, sub 001, and 010, or 011, slt 100, xor 101

Behaviour:
- Reset: on a clk edge with rst=1, state <= FETCH. While rst=1, all write enables (PCWrite, MemWrite, IRWrite, RegWrite) are forced to 0. All selects default to 0.
- Any output not listed for a state is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut <= OldPC+imm). ImmSrc comes from opcode.
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI.
  - Other opcodes -> ILLEGAL handling (see Optional Feature).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from the ALU decoder. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl from the ALU decoder. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. Next state: FETCH.
  - PCWrite by func3: 000 beq = zero; 001 bne = ~zero; 100 blt = negative; 101 bge = ~negative.
  - Other func3 values: PCWrite=0.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next state: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, add. Next state: JALRPC.
- JALRPC: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next state: ALUWB.
- LUI: ImmSrc=100, ResultSrc=11, RegWrite=1. Next state: FETCH.
- ALU decoder (EXECR / EXECI):
  - func3 000: add, or sub when R-type and func7[5]=1.
  - func3 010: slt; 100: xor; 110: or; 111: and.
  - Other func3 values: add, and the instruction is flagged illegal.
- Cycles per instruction: lui 3, branch 3, R/I/sw/jal 4, lw/jalr 5.
- Reset mid-instruction: the next state is FETCH regardless of the current state. No partial writes occur during the reset cycle.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Enabled:
  - Extra output illegal (1 bit).
  - An unknown opcode, or an unsupported func3 in DECODE, goes to HALT.
  - HALT holds all enables at 0 with illegal=1 until rst.
- Disabled:
  - No illegal port.
  - Unknown opcodes go DECODE -> FETCH as a NOP (2 cycles).
  - Bad func3 executes as add.

Decomposition:
- Package riscv_mc_pkg holds:
  - opcode constants;
  - state enum;
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB codes.
- Sub-module mc_alu_decoder: combinational; inputs func3, func7[5], is_rtype; outputs ALUControl and bad_funct.

Test Plan:
- rst=1 for 2 cycles, from any state -> state FETCH, all enables 0; first cycle after release: IRWrite=1, PCWrite=1.
- R-type sub (opcode 0110011, func3 000, func7 0100000) -> states FETCH, DECODE, EXECR (ALUControl=001), ALUWB (RegWrite=1) -> FETCH; 4 cycles.
- lw (0000011) -> 5 cycles, MEMREAD AdrSrc=1, MEMWB ResultSrc=01. sw (0100011) -> MEMWRITE MemWrite=1, 4 cycles.
- beq (1100011, func3 000): zero=1 -> PCWrite=1 in BRANCH; zero=0 -> 0. blt: negative=1 -> 1.
- jalr (1100111) -> JALR, then JALRPC with PCWrite=1, then ALUWB with RegWrite=1; 5 cycles. lui (0110111) -> ResultSrc=11, ImmSrc=100, 3 cycles.
- Opcode 1111111: with MC_ILLEGAL_TRAP_EN -> HALT, illegal=1, held 10 cycles until rst. Without it -> back to FETCH after DECODE, no writes.
